// File: rtl/mole_game_core.sv
// Whac-a-mole game engine: spawns moles, times their windows,
// scores hits against the one-hot hammer position and tracks lives.
module mole_game_core #(
  parameter int MOLE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int LIVES       = 3,
  parameter int TIMER_W     = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       whack,
  input  logic [9:0] board_posit,
  output logic [9:0] mole_posit,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       hit,
  output logic       miss,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    GAP,
    OVER
  } state_t;

  localparam logic [TIMER_W-1:0] MOLE_W = TIMER_W'(MOLE_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_T  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [1:0]         LIVES_L = 2'(LIVES);

  state_t               state;
  logic [15:0]          lfsr;
  logic [TIMER_W-1:0]   timer;
  logic [3:0]           prev_idx;
  logic                 start_q;
  logic                 whack_q;

  logic                 start_p;
  logic                 whack_p;
  logic [1:0]           level;
  logic [TIMER_W-1:0]   window;
  logic [3:0]           idx_fold;
  logic [3:0]           idx_next;
  logic                 match;
  logic                 lfsr_fb;

  // Button edges, level/window, next mole index and hit match
  always_comb begin
    start_p  = start & ~start_q;
    whack_p  = whack & ~whack_q;
    level    = (score[7:5] != 3'd0) ? 2'd3 : score[4:3];
    window   = MOLE_W >> level;
    idx_fold = (lfsr[3:0] > 4'd9) ? lfsr[3:0] - 4'd6 : lfsr[3:0];
    idx_next = idx_fold;
    if (idx_fold == prev_idx)
      idx_next = (idx_fold == 4'd9) ? 4'd0 : idx_fold + 4'd1;
    match    = whack_p && (board_posit == mole_posit);
    lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  end

  // Game state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= 16'hACE1;
      timer      <= '0;
      prev_idx   <= 4'd0;
      start_q    <= 1'b0;
      whack_q    <= 1'b0;
      mole_posit <= '0;
      score      <= '0;
      lives      <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      start_q <= start;
      whack_q <= whack;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      hit     <= 1'b0;
      miss    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_p) begin
            score <= '0;
            lives <= LIVES_L;
            state <= SPAWN;
          end
        end
        SPAWN: begin
          mole_posit <= 10'b1 << idx_next;
          prev_idx   <= idx_next;
          timer      <= window - 1'b1;
          state      <= UP;
        end
        UP: begin
          if (timer != '0)
            timer <= timer - 1'b1;
          if (match) begin
            if (score != 8'hFF)
              score <= score + 8'd1;
            hit        <= 1'b1;
            mole_posit <= '0;
            timer      <= GAP_T;
            state      <= GAP;
          end else if (timer == '0) begin
            miss       <= 1'b1;
            mole_posit <= '0;
            lives      <= lives - 2'd1;
            if (lives == 2'd1) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              timer <= GAP_T;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (timer == '0)
            state <= SPAWN;
          else
            timer <= timer - 1'b1;
        end
        OVER: begin
          if (start_p) begin
            score     <= '0;
            lives     <= LIVES_L;
            game_over <= 1'b0;
            state     <= SPAWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_core.sv
// Scoreboard bench for mole_game_core: hit/miss events are queued
// as expected and checked by a monitor when the DUT pulses them.
module tb_mole_game_core;

  logic       clk;
  logic       rst;
  logic       start;
  logic       whack;
  logic [9:0] board_posit;
  logic [9:0] mole_posit;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit;
  logic       miss;
  logic       game_over;

  mole_game_core #(
    .MOLE_CYCLES(16),
    .GAP_CYCLES (4),
    .LIVES      (3),
    .TIMER_W    (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .whack      (whack),
    .board_posit(board_posit),
    .mole_posit (mole_posit),
    .score      (score),
    .lives      (lives),
    .hit        (hit),
    .miss       (miss),
    .game_over  (game_over)
  );

  typedef struct {
    bit         is_hit;
    logic [7:0] sc;
    logic [1:0] lv;
  } ev_t;

  ev_t        q[$];
  int         n_pass;
  int         n_total;
  logic [7:0] exp_score;
  logic [1:0] exp_lives;
  logic [9:0] prev_mole;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_ev(input bit h);
    ev_t e;
    if (h) begin
      if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
    end else begin
      exp_lives = exp_lives - 2'd1;
    end
    e.is_hit = h;
    e.sc     = exp_score;
    e.lv     = exp_lives;
    q.push_back(e);
  endtask

  // Monitor: every hit/miss pulse must match the next queued event
  always @(negedge clk) begin
    if (!rst && (hit || miss)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, hit, miss}, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_hit", hit, e.is_hit);
        chk("ev_miss", miss, !e.is_hit);
        chk("ev_score", score, e.sc);
        chk("ev_lives", lives, e.lv);
        chk("ev_mole_clear", mole_posit, 0);
      end
    end
  end

  task automatic wait_mole();
    int n;
    n = 0;
    while (mole_posit == 10'd0 && n < 100) begin
      step();
      n++;
    end
    chk("mole_onehot", $onehot(mole_posit), 1);
    chk("mole_new", mole_posit != prev_mole, 1);
    prev_mole = mole_posit;
  endtask

  task automatic wait_over();
    int n;
    n = 0;
    while (!game_over && n < 200) begin
      step();
      n++;
    end
    chk("over_wait", game_over, 1);
  endtask

  task automatic measure(input int exp_w);
    int cnt;
    push_ev(1'b0);
    wait_mole();
    cnt = 1;
    while (mole_posit != 10'd0 && cnt < 200) begin
      step();
      if (mole_posit != 10'd0) cnt++;
    end
    chk("window_len", cnt, exp_w);
  endtask

  task automatic hit_at(input int delay);
    int cnt;
    wait_mole();
    cnt = 1;
    while (cnt < delay && mole_posit != 10'd0) begin
      step();
      cnt++;
    end
    chk("mole_alive", mole_posit != 10'd0, 1);
    push_ev(1'b1);
    board_posit = mole_posit;
    whack = 1'b1;
    step();
    whack = 1'b0;
    board_posit = 10'd0;
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_score = 8'd0;
    exp_lives = 2'd3;
    chk("restart_over", game_over, 0);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
  endtask

  logic [9:0] nm_board [7];
  logic       nm_whack [7];

  initial begin
    int cnt;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start = 1'b0;
    whack = 1'b0;
    board_posit = 10'd0;
    prev_mole = 10'b1;
    exp_score = 8'd0;
    exp_lives = 2'd0;

    step();
    whack = 1'b1;
    step();
    whack = 1'b0;
    chk("rst_mole", mole_posit, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 0);
    chk("rst_flags", {hit, miss, game_over}, 0);
    rst = 1'b0;
    whack = 1'b1;
    step();
    whack = 1'b0;
    step();
    chk("idle_mole", mole_posit, 0);
    chk("idle_lives", lives, 0);
    chk("idle_over", game_over, 0);

    exp_lives = 2'd3;
    push_ev(1'b0);
    push_ev(1'b0);
    push_ev(1'b0);
    start = 1'b1;
    step();
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    chk("spawn_mole", mole_posit, 0);
    measure(16);
    q.pop_back();
    repeat (30) step();
    start = 1'b0;
    wait_over();
    chk("over_mole", mole_posit, 0);
    chk("over_lives", lives, 0);
    chk("over_score", score, 0);

    start_game();
    wait_mole();
    push_ev(1'b1);
    board_posit = mole_posit;
    whack = 1'b1;
    step();
    chk("hit_clear", mole_posit, 0);
    chk("hit_score", score, 1);
    cnt = 1;
    while (mole_posit == 10'd0 && cnt < 50) begin
      step();
      if (mole_posit == 10'd0) cnt++;
    end
    chk("gap_len", cnt, 5);
    chk("next_onehot", $onehot(mole_posit), 1);
    chk("next_new", mole_posit != prev_mole, 1);
    prev_mole = mole_posit;

    push_ev(1'b0);
    nm_board[0] = 10'd0;
    nm_board[1] = {mole_posit[8:0], mole_posit[9]};
    nm_board[2] = nm_board[1];
    nm_board[3] = 10'b0000000011;
    nm_board[4] = 10'b0000000011;
    nm_board[5] = 10'd0;
    nm_board[6] = 10'd0;
    nm_whack[0] = 1'b0;
    nm_whack[1] = 1'b1;
    nm_whack[2] = 1'b0;
    nm_whack[3] = 1'b1;
    nm_whack[4] = 1'b0;
    nm_whack[5] = 1'b1;
    nm_whack[6] = 1'b0;
    cnt = 1;
    for (int i = 0; i < 7; i++) begin
      board_posit = nm_board[i];
      whack = nm_whack[i];
      step();
      if (mole_posit != 10'd0) cnt++;
    end
    board_posit = 10'd0;
    chk("nomatch_score", score, 1);
    while (mole_posit != 10'd0 && cnt < 100) begin
      step();
      if (mole_posit != 10'd0) cnt++;
    end
    chk("nomatch_window", cnt, 16);
    chk("nomatch_lives", lives, 2);

    while (exp_score < 8'd8) hit_at(1);
    measure(8);
    hit_at(8);
    while (exp_score < 8'd24) hit_at(1);
    measure(2);
    wait_over();
    chk("over2_score", score, 24);
    chk("over2_mole", mole_posit, 0);
    chk("over2_lives", lives, 0);

    start_game();
    while (exp_score < 8'd255) hit_at(1);
    hit_at(1);
    step();
    chk("sat_score", score, 255);

    wait_mole();
    rst = 1'b1;
    step();
    chk("midrst_mole", mole_posit, 0);
    chk("midrst_score", score, 0);
    chk("midrst_lives", lives, 0);
    chk("midrst_flags", {hit, miss, game_over}, 0);
    rst = 1'b0;
    step();
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
